// File: rtl/multicycle_controller.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait states,
// a memory timeout trap, HALT, conditional branches and a retired-instruction counter.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       lasttwoBits,
  input  logic [2:0]       lastthreeBits,
  input  logic [2:0]       threeBitFn,
  input  logic [1:0]       twoBitFn,
  input  logic             zero_flag,
  input  logic             carry_flag,
  input  logic             mem_ready,
  output logic [1:0]       selectToWrite,
  output logic             selectR2,
  output logic [1:0]       selectAluArg,
  output logic [2:0]       ALUfunction,
  output logic [1:0]       sh_roFunction,
  output logic             pc_src,
  output logic             enablePC,
  output logic             enableZero,
  output logic             enableCarry,
  output logic             ir_load,
  output logic             reg_write,
  output logic             memRead,
  output logic             memWrite,
  output logic             STM,
  output logic             LDM,
  output logic [2:0]       state,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic is_misc, is_ldm, is_stm, is_halt, is_branch, taken, timeout;

  assign is_misc   = (lasttwoBits == 2'b11);
  assign is_ldm    = is_misc && (lastthreeBits == 3'b000);
  assign is_stm    = is_misc && (lastthreeBits == 3'b001);
  assign is_halt   = is_misc && (lastthreeBits == 3'b111);
  assign is_branch = is_misc && lastthreeBits[2] && !is_halt;
  assign taken     = is_misc && ((lastthreeBits == 3'b100) ||
                                 ((lastthreeBits == 3'b101) && zero_flag) ||
                                 ((lastthreeBits == 3'b110) && carry_flag));
  // A ready in the last allowed wait cycle still wins over the trap.
  assign timeout   = (MEM_TIMEOUT != 0) && !mem_ready &&
                     (wait_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_ERROR;
        else              wait_d  = wait_q + TO_W'(1);
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (!is_misc)               state_d = S_WB;
        else if (is_ldm || is_stm)  state_d = S_MEM;
        else begin
          state_d   = is_halt ? S_HALT : S_FETCH;
          retired_d = retired_q + CNT_W'(1);
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_ldm) state_d = S_WB;
          else begin
            state_d   = S_FETCH;
            retired_d = retired_q + CNT_W'(1);
          end
        end else if (timeout) state_d = S_ERROR;
        else                  wait_d  = wait_q + TO_W'(1);
      end
      S_WB: begin
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are masked while reset is held so an aborted access cannot leak out.
  always_comb begin
    selectToWrite = 2'b00;
    selectR2      = 1'b0;
    selectAluArg  = 2'b00;
    ALUfunction   = 3'b000;
    sh_roFunction = 2'b00;
    pc_src        = 1'b0;
    enablePC      = 1'b0;
    enableZero    = 1'b0;
    enableCarry   = 1'b0;
    ir_load       = 1'b0;
    reg_write     = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    STM           = 1'b0;
    LDM           = 1'b0;
    halted        = 1'b0;
    error         = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          memRead  = 1'b1;
          ir_load  = mem_ready;
          enablePC = mem_ready;
        end
        S_EXEC: begin
          if (!is_misc) begin
            if (lasttwoBits == 2'b10) sh_roFunction = twoBitFn;
            else begin
              ALUfunction  = threeBitFn;
              selectAluArg = lasttwoBits;
            end
          end else if (is_ldm || is_stm) begin
            selectAluArg = 2'b01;
          end else if (is_branch) begin
            selectAluArg = 2'b10;
            enablePC     = taken;
            pc_src       = taken;
          end
        end
        S_MEM: begin
          if (is_ldm) begin
            memRead = 1'b1;
            LDM     = 1'b1;
          end else begin
            memWrite = 1'b1;
            STM      = 1'b1;
            selectR2 = 1'b1;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          if (is_ldm) selectToWrite = 2'b10;
          else begin
            selectToWrite = (lasttwoBits == 2'b10) ? 2'b01 : 2'b00;
            enableZero    = 1'b1;
            enableCarry   = 1'b1;
          end
        end
        S_HALT:  halted = 1'b1;
        S_ERROR: error  = 1'b1;
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level reference model pushes the expected
// per-cycle output vector into a queue; a negedge monitor pops and compares each cycle.
module tb_multicycle_controller;

  localparam int TO = 4;
  localparam int CW = 2;
  localparam int W  = 27;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    lasttwoBits;
  logic [2:0]    lastthreeBits;
  logic [2:0]    threeBitFn;
  logic [1:0]    twoBitFn;
  logic          zero_flag, carry_flag, mem_ready;
  logic [1:0]    selectToWrite, selectAluArg, sh_roFunction;
  logic [2:0]    ALUfunction, state;
  logic          selectR2, pc_src, enablePC, enableZero, enableCarry, ir_load, reg_write;
  logic          memRead, memWrite, STM, LDM, halted, error;
  logic [CW-1:0] retired;

  multicycle_controller #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .lasttwoBits(lasttwoBits), .lastthreeBits(lastthreeBits),
    .threeBitFn(threeBitFn), .twoBitFn(twoBitFn), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .mem_ready(mem_ready), .selectToWrite(selectToWrite),
    .selectR2(selectR2), .selectAluArg(selectAluArg), .ALUfunction(ALUfunction),
    .sh_roFunction(sh_roFunction), .pc_src(pc_src), .enablePC(enablePC),
    .enableZero(enableZero), .enableCarry(enableCarry), .ir_load(ir_load),
    .reg_write(reg_write), .memRead(memRead), .memWrite(memWrite), .STM(STM), .LDM(LDM),
    .state(state), .halted(halted), .error(error), .retired(retired)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ret_m    = 0;

  logic [2:0] e_state, e_alu;
  logic [1:0] e_wr, e_arg, e_sh;
  logic e_r2, e_pcs, e_pc, e_z, e_c, e_ir, e_rw, e_mr, e_mw, e_stm, e_ldm, e_halt, e_err;

  logic [W-1:0] act;
  assign act = {state, selectToWrite, selectR2, selectAluArg, ALUfunction, sh_roFunction,
                pc_src, enablePC, enableZero, enableCarry, ir_load, reg_write, memRead,
                memWrite, STM, LDM, halted, error, retired};

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL cycle_vector t=%0t state=%0d got=%h exp=%h", $time, state, act, e);
      end
    end
  end

  // driver tasks
  task automatic clr(input int st);
    e_state = 3'(st); e_wr = 2'b00; e_r2 = 1'b0; e_arg = 2'b00; e_alu = 3'b000;
    e_sh = 2'b00; e_pcs = 1'b0; e_pc = 1'b0; e_z = 1'b0; e_c = 1'b0; e_ir = 1'b0;
    e_rw = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_stm = 1'b0; e_ldm = 1'b0;
    e_halt = 1'b0; e_err = 1'b0;
  endtask

  task automatic cyc(input logic rdy);
    mem_ready = rdy;
    exp_q.push_back({e_state, e_wr, e_r2, e_arg, e_alu, e_sh, e_pcs, e_pc, e_z, e_c, e_ir,
                     e_rw, e_mr, e_mw, e_stm, e_ldm, e_halt, e_err, CW'(ret_m)});
    @(posedge clk); #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    ret_m = 0;
    clr(0);
    cyc(1'b0);
    n_checks++;
    if (state !== 3'd0 || retired !== '0 || memRead !== 1'b0 || LDM !== 1'b0 ||
        error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state t=%0t state=%0d retired=%0d memRead=%b LDM=%b error=%b",
               $time, state, retired, memRead, LDM, error);
    end
    cyc(1'b1);
    rst = 1'b1;
  endtask

  task automatic error_then_reset();
    n_checks++;
    if (state !== 3'd6 || error !== 1'b1 || memRead !== 1'b0) begin
      n_fail++;
      $display("FAIL expired_wait t=%0t state=%0d error=%b memRead=%b",
               $time, state, error, memRead);
    end
    for (int k = 0; k < 3; k++) begin
      clr(6); e_err = 1'b1; cyc(rnd_bit());
    end
    do_reset();
  endtask

  // Reference model: one instruction, fw/mw low-ready cycles before fetch/memory accept.
  task automatic run_instr(input logic [1:0] cls, input logic [2:0] sub, input logic [2:0] f3,
                           input logic [1:0] f2, input logic z, input logic c,
                           input int fw, input int mw, input bit abort);
    bit misc, ldm, stm, halt, br, tk;
    lasttwoBits = cls; lastthreeBits = sub; threeBitFn = f3; twoBitFn = f2;
    zero_flag = z; carry_flag = c;
    misc = (cls == 2'b11);
    ldm  = misc && (sub == 3'd0);
    stm  = misc && (sub == 3'd1);
    halt = misc && (sub == 3'd7);
    br   = misc && (sub inside {3'd4, 3'd5, 3'd6});
    tk   = misc && ((sub == 3'd4) || ((sub == 3'd5) && z) || ((sub == 3'd6) && c));

    for (int k = 0; k < fw; k++) begin
      clr(0); e_mr = 1'b1; cyc(1'b0);
      if (k == TO - 1) begin error_then_reset(); return; end
    end
    clr(0); e_mr = 1'b1; e_ir = 1'b1; e_pc = 1'b1; cyc(1'b1);
    clr(1); cyc(rnd_bit());

    clr(2);
    if (!misc) begin
      if (cls == 2'b10) e_sh = f2;
      else begin e_alu = f3; e_arg = cls; end
    end else if (ldm || stm) e_arg = 2'b01;
    else if (br) begin e_arg = 2'b10; e_pc = tk; e_pcs = tk; end
    cyc(rnd_bit());

    if (misc && !ldm && !stm) begin
      ret_m = (ret_m + 1) % (1 << CW);
      if (halt) begin
        for (int k = 0; k < 20; k++) begin clr(5); e_halt = 1'b1; cyc(rnd_bit()); end
        do_reset();
      end
      return;
    end

    if (ldm || stm) begin
      for (int k = 0; k < mw; k++) begin
        clr(3);
        if (ldm) begin e_mr = 1'b1; e_ldm = 1'b1; end
        else begin e_mw = 1'b1; e_stm = 1'b1; e_r2 = 1'b1; end
        cyc(1'b0);
        if (k == TO - 1) begin error_then_reset(); return; end
      end
      if (abort) begin do_reset(); return; end
      clr(3);
      if (ldm) begin e_mr = 1'b1; e_ldm = 1'b1; end
      else begin e_mw = 1'b1; e_stm = 1'b1; e_r2 = 1'b1; end
      cyc(1'b1);
      if (stm) begin ret_m = (ret_m + 1) % (1 << CW); return; end
    end

    clr(4);
    e_rw = 1'b1;
    e_wr = ldm ? 2'b10 : ((cls == 2'b10) ? 2'b01 : 2'b00);
    e_z  = !ldm;
    e_c  = !ldm;
    cyc(rnd_bit());
    ret_m = (ret_m + 1) % (1 << CW);
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 19) == 0) return TO;
    return int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    rst = 1'b0; mem_ready = 1'b0; lasttwoBits = 2'b00; lastthreeBits = 3'b000;
    threeBitFn = 3'b000; twoBitFn = 2'b00; zero_flag = 1'b0; carry_flag = 1'b0;
    @(posedge clk); #1;
    do_reset();

    run_instr(2'b00, 3'b000, 3'b010, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0);  // ALU rr
    run_instr(2'b01, 3'b000, 3'b101, 2'b00, 1'b1, 1'b0, 1, 0, 1'b0);  // ALU imm
    run_instr(2'b10, 3'b000, 3'b000, 2'b11, 1'b0, 1'b1, 0, 0, 1'b0);  // shift
    run_instr(2'b11, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 0, 3, 1'b0);  // LDM, 3 waits
    run_instr(2'b11, 3'b001, 3'b000, 2'b00, 1'b0, 1'b0, 0, 2, 1'b0);  // STM
    run_instr(2'b11, 3'b101, 3'b000, 2'b00, 1'b1, 1'b0, 0, 0, 1'b0);  // BZ taken
    run_instr(2'b11, 3'b101, 3'b000, 2'b00, 1'b0, 1'b1, 0, 0, 1'b0);  // BZ not taken
    run_instr(2'b11, 3'b110, 3'b000, 2'b00, 1'b0, 1'b1, 0, 0, 1'b0);  // BC taken
    run_instr(2'b11, 3'b100, 3'b000, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0);  // JMP
    run_instr(2'b00, 3'b000, 3'b001, 2'b00, 1'b0, 1'b0, 3, 0, 1'b0);  // ready on last wait
    run_instr(2'b00, 3'b000, 3'b001, 2'b00, 1'b0, 1'b0, 6, 0, 1'b0);  // fetch timeout
    run_instr(2'b11, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 0, 5, 1'b0);  // MEM timeout
    run_instr(2'b11, 3'b111, 3'b000, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0);  // HALT
    run_instr(2'b00, 3'b000, 3'b011, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(2'b11, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 0, 2, 1'b1);  // reset mid-LDM
    for (int i = 0; i < 5; i++)                                         // retired wrap
      run_instr(2'b11, 3'b010, 3'b000, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      run_instr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 6)), 3'($urandom),
                2'($urandom), rnd_bit(), rnd_bit(), pick_wait(), pick_wait(), 1'b0);
    end

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
